// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolver: target and mispredict check, registered PC redirect,
// flush sequencing and a 2-bit saturating branch history table.
module branch_resolve_unit #(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned PC_WIDTH        = 20,
   parameter int unsigned PC_OFFSET_WIDTH = 18,
   parameter int unsigned BHT_ENTRIES     = 16,
   parameter int unsigned FLUSH_CYCLES    = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       resolve_valid_in,
   input  logic                       jmp_inst_in,
   input  logic                       jmp_use_r_in,
   input  logic                       branch_inst_in,
   input  logic                       branch_result_in,
   input  logic [PC_WIDTH-1:0]        pc_in,
   input  logic [DATA_WIDTH-1:0]      reg_a_data_in,
   input  logic [DATA_WIDTH-1:0]      reg_b_data_in,
   input  logic [PC_OFFSET_WIDTH-1:0] pc_offset_in,
   input  logic                       pred_taken_in,
   input  logic [PC_WIDTH-1:0]        pred_target_in,
   input  logic [PC_WIDTH-1:0]        lookup_pc_in,
   output logic                       predict_taken_out,
   output logic                       select_new_pc_out,
   output logic [PC_WIDTH-1:0]        pc_out,
   output logic                       flush_out
);

   localparam int unsigned IdxW = $clog2(BHT_ENTRIES);
   localparam int unsigned CntW = ($clog2(FLUSH_CYCLES + 1) > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

   typedef enum logic [0:0] {StIdle, StFlush} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              sel_q;
   logic [PC_WIDTH-1:0] pc_q;
   logic              pred_q;
   logic [1:0]        bht_q [BHT_ENTRIES];

   logic [PC_WIDTH-1:0] branch_target, jump_target, fall_through, target;
   logic                taken, mispredict, accept, redirect, bht_update;
   logic [IdxW-1:0]     upd_idx, lookup_idx;
   logic [1:0]          bht_cur, bht_next;
   logic                unused_bits;

   // Register operands are wider than the PC; only the low bits matter after truncation.
   assign unused_bits = ^{reg_a_data_in, reg_b_data_in, lookup_pc_in};

   always_comb begin
      branch_target = pc_in + {reg_b_data_in[PC_WIDTH-3:0], 2'b00};
      jump_target   = jmp_use_r_in ? reg_a_data_in[PC_WIDTH-1:0]
                                   : PC_WIDTH'({pc_offset_in, 2'b00});
      fall_through  = pc_in + PC_WIDTH'(4);
      target        = jmp_inst_in ? jump_target : branch_target;
      taken         = jmp_inst_in | (branch_inst_in & branch_result_in);
      mispredict    = (taken != pred_taken_in) | (taken & (target != pred_target_in));
      accept        = resolve_valid_in & (state_q == StIdle);
      redirect      = accept & mispredict;
      bht_update    = accept & branch_inst_in & ~jmp_inst_in;
      upd_idx       = pc_in[IdxW+1:2];
      lookup_idx    = lookup_pc_in[IdxW+1:2];
   end

   always_comb begin
      bht_cur  = bht_q[upd_idx];
      bht_next = bht_cur;
      if (branch_result_in) begin
         if (bht_cur != 2'b11) bht_next = bht_cur + 2'b01;
      end else begin
         if (bht_cur != 2'b00) bht_next = bht_cur - 2'b01;
      end
   end

   // Counter is preloaded with FLUSH_CYCLES-1 so the FLUSH state lasts exactly FLUSH_CYCLES.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (redirect) begin
               state_d = StFlush;
               cnt_d   = CntW'(FLUSH_CYCLES - 1);
            end
         end
         StFlush: begin
            if (cnt_q == '0) state_d = StIdle;
            else             cnt_d   = cnt_q - CntW'(1);
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         sel_q   <= 1'b0;
         pc_q    <= '0;
         pred_q  <= 1'b0;
         for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= redirect;
         if (redirect) pc_q <= taken ? target : fall_through;
         // Read before write: same-index lookup sees the pre-update counter.
         pred_q  <= bht_q[lookup_idx][1];
         if (bht_update) bht_q[upd_idx] <= bht_next;
      end
   end

   assign predict_taken_out = pred_q;
   assign select_new_pc_out = sel_q;
   assign pc_out            = pc_q;
   assign flush_out         = (state_q == StFlush);

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        resolve_valid_in, jmp_inst_in, jmp_use_r_in, branch_inst_in, branch_result_in;
   logic [19:0] pc_in, pred_target_in, lookup_pc_in;
   logic [31:0] reg_a_data_in, reg_b_data_in;
   logic [17:0] pc_offset_in;
   logic        pred_taken_in;
   logic        predict_taken_out, select_new_pc_out, flush_out;
   logic [19:0] pc_out;

   int errors = 0;
   int checks = 0;

   branch_resolve_unit dut (
      .clk               (clk),
      .rst               (rst),
      .resolve_valid_in  (resolve_valid_in),
      .jmp_inst_in       (jmp_inst_in),
      .jmp_use_r_in      (jmp_use_r_in),
      .branch_inst_in    (branch_inst_in),
      .branch_result_in  (branch_result_in),
      .pc_in             (pc_in),
      .reg_a_data_in     (reg_a_data_in),
      .reg_b_data_in     (reg_b_data_in),
      .pc_offset_in      (pc_offset_in),
      .pred_taken_in     (pred_taken_in),
      .pred_target_in    (pred_target_in),
      .lookup_pc_in      (lookup_pc_in),
      .predict_taken_out (predict_taken_out),
      .select_new_pc_out (select_new_pc_out),
      .pc_out            (pc_out),
      .flush_out         (flush_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      resolve_valid_in = 0; jmp_inst_in = 0; jmp_use_r_in = 0;
      branch_inst_in = 0; branch_result_in = 0; pc_in = '0;
      reg_a_data_in = '0; reg_b_data_in = '0; pc_offset_in = '0;
      pred_taken_in = 0; pred_target_in = '0;
   endtask

   task automatic branch(input logic [19:0] pc, input logic [31:0] off, input logic res,
                         input logic ptaken, input logic [19:0] ptgt);
      idle();
      resolve_valid_in = 1; branch_inst_in = 1; branch_result_in = res;
      pc_in = pc; reg_b_data_in = off; pred_taken_in = ptaken; pred_target_in = ptgt;
   endtask

   initial begin
      idle();
      lookup_pc_in = '0;
      rst = 1;
      tick(); tick();
      check("rst_sel", {31'b0, select_new_pc_out}, 0);
      check("rst_pc", {12'b0, pc_out}, 0);
      check("rst_flush", {31'b0, flush_out}, 0);
      check("rst_pred", {31'b0, predict_taken_out}, 0);
      rst = 0;
      for (int i = 0; i < 16; i++) begin
         lookup_pc_in = 20'(i << 2);
         tick();
         check("rst_lookup", {31'b0, predict_taken_out}, 0);
      end
      lookup_pc_in = '0;

      // Taken branch predicted not taken: 0x100 + 3*4
      branch(20'h100, 32'd3, 1, 0, 20'h0);
      tick();
      check("br_sel", {31'b0, select_new_pc_out}, 1);
      check("br_pc", {12'b0, pc_out}, 32'h10C);
      check("br_flush1", {31'b0, flush_out}, 1);
      idle();
      tick();
      check("br_sel_pulse", {31'b0, select_new_pc_out}, 0);
      check("br_flush2", {31'b0, flush_out}, 1);
      check("br_pc_hold", {12'b0, pc_out}, 32'h10C);
      tick();
      check("br_flush_end", {31'b0, flush_out}, 0);

      // Not-taken branch predicted taken -> fall-through
      branch(20'h100, 32'hFFFF_FFFF, 0, 1, 20'h0FC);
      tick();
      check("nt_sel", {31'b0, select_new_pc_out}, 1);
      check("nt_pc", {12'b0, pc_out}, 32'h104);
      idle(); tick(); tick();
      // Correctly predicted backward taken branch
      branch(20'h100, 32'hFFFF_FFFF, 1, 1, 20'h0FC);
      tick();
      check("ok_sel", {31'b0, select_new_pc_out}, 0);
      check("ok_flush", {31'b0, flush_out}, 0);
      idle();

      // Register jump truncated to PC width
      resolve_valid_in = 1; jmp_inst_in = 1; jmp_use_r_in = 1; reg_a_data_in = 32'hFFFF_F040;
      tick();
      check("jr_sel", {31'b0, select_new_pc_out}, 1);
      check("jr_pc", {12'b0, pc_out}, 32'hFF040);
      idle(); tick(); tick();
      // Immediate jump also taken by priority over branch
      resolve_valid_in = 1; jmp_inst_in = 1; branch_inst_in = 1; pc_offset_in = 18'h0_1234;
      tick();
      check("ji_pc", {12'b0, pc_out}, 32'h048D0);
      idle(); tick(); tick();
      // Fall-through wraps
      branch(20'hFFFFC, 32'd5, 0, 1, 20'h0);
      tick();
      check("wrap_sel", {31'b0, select_new_pc_out}, 1);
      check("wrap_pc", {12'b0, pc_out}, 32'h0);
      idle(); tick(); tick();

      // Resolves during flush are squashed
      branch(20'h00C, 32'd1, 1, 0, 20'h0);
      tick();
      check("fl_pc0", {12'b0, pc_out}, 32'h010);
      branch(20'h010, 32'd2, 1, 0, 20'h0);
      tick();
      check("fl_sq1_sel", {31'b0, select_new_pc_out}, 0);
      tick();
      check("fl_sq2_sel", {31'b0, select_new_pc_out}, 0);
      check("fl_sq_pc", {12'b0, pc_out}, 32'h010);
      check("fl_dropped", {31'b0, flush_out}, 0);
      branch(20'h010, 32'd2, 0, 1, 20'h018);
      tick();
      check("fl_acc_sel", {31'b0, select_new_pc_out}, 1);
      check("fl_acc_pc", {12'b0, pc_out}, 32'h014);
      idle(); tick(); tick();
      lookup_pc_in = 20'h010;
      tick();
      check("fl_no_train", {31'b0, predict_taken_out}, 0);
      lookup_pc_in = 20'h00C;
      tick();
      check("fl_idx3_train", {31'b0, predict_taken_out}, 1);

      // Saturation at index 5
      lookup_pc_in = 20'h014;
      for (int i = 0; i < 3; i++) begin
         branch(20'h014, 32'd0, 1, 1, 20'h014);
         tick();
         check("sat_nosel", {31'b0, select_new_pc_out}, 0);
      end
      idle();
      tick();
      check("sat_pred", {31'b0, predict_taken_out}, 1);
      branch(20'h014, 32'd0, 0, 0, 20'h0);
      tick();
      check("rbw_pred", {31'b0, predict_taken_out}, 1);
      idle();
      tick();
      check("ctr2_pred", {31'b0, predict_taken_out}, 1);
      branch(20'h014, 32'd0, 0, 0, 20'h0);
      tick();
      idle();
      tick();
      check("ctr1_pred", {31'b0, predict_taken_out}, 0);

      // Reset during flush
      branch(20'h020, 32'd1, 1, 0, 20'h0);
      tick();
      check("mid_flush", {31'b0, flush_out}, 1);
      idle();
      rst = 1;
      tick();
      check("rst_mid_flush", {31'b0, flush_out}, 0);
      check("rst_mid_sel", {31'b0, select_new_pc_out}, 0);
      check("rst_mid_pc", {12'b0, pc_out}, 0);
      rst = 0;
      lookup_pc_in = 20'h00C;
      tick();
      check("rst_after_flush", {31'b0, flush_out}, 0);
      check("rst_bht_cleared", {31'b0, predict_taken_out}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
